piso_serializer: RTL and testbench

Parallel-in, serial-out serializer with a valid/ready load port and a one-word holding buffer. It is the upstream stage of the SIPO shift register: it emits each word LSB-first on a 1-bit line with a per-bit valid and a last-bit marker. The SIPO shifts new bits in at its MSB end, so after WIDTH shifts it holds the word in its original bit order. The holding buffer allows back-to-back words to stream with no idle bit between them.

---
 rtl/piso_serializer_if.sv | 23 ++
 rtl/piso_serializer.sv | 71 +++++++
 tb/tb_piso_serializer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
// Load port and serial output bundle for piso_serializer.
// Valid/ready: a word moves on a rising edge where load_valid && load_ready; load_ready never depends on load_valid.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;
  logic             busy;

  modport master (
    output load_valid, load_data,
    input  load_ready, ser_out, ser_valid, ser_last, busy
  );

  modport slave (
    input  load_valid, load_data,
    output load_ready, ser_out, ser_valid, ser_last, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer, LSB first, with a one-word holding buffer
// so consecutive words stream with no idle bit between them.
module piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  piso_serializer_if.slave  bus,
  output logic              state_dbg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] hold_reg;
  logic             hold_full;
  logic [WIDTH-1:0] sh_reg;
  logic [CW-1:0]    bit_cnt;

  logic at_last;
  logic shifter_free;
  logic accept;
  logic transfer;

  assign at_last      = (bit_cnt == LAST_BIT);
  assign shifter_free = (state == IDLE) || ((state == SHIFT) && at_last);
  assign accept       = bus.load_valid && !hold_full;
  // accept and transfer are mutually exclusive: accept needs an empty buffer
  assign transfer     = shifter_free && hold_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      sh_reg    <= '0;
      bit_cnt   <= '0;
    end else begin
      if (accept) begin
        hold_reg  <= bus.load_data;
        hold_full <= 1'b1;
      end
      if (transfer) begin
        sh_reg    <= hold_reg;
        bit_cnt   <= '0;
        state     <= SHIFT;
        hold_full <= 1'b0;
      end else if (state == SHIFT) begin
        if (!at_last) begin
          sh_reg  <= {1'b0, sh_reg[WIDTH-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end else begin
          state  <= IDLE;
          sh_reg <= '0;
        end
      end
    end
  end

  assign bus.load_ready = !hold_full;
  assign bus.ser_valid  = (state == SHIFT);
  assign bus.ser_out    = sh_reg[0] && bus.ser_valid;
  assign bus.ser_last   = bus.ser_valid && at_last;
  assign bus.busy       = bus.ser_valid || hold_full;
  assign state_dbg      = state[0];

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed vector table, multi-cycle corner sequences,
// and randomized words checked by a word-level scoreboard with a SIPO loopback.
module tb_piso_serializer;
  localparam int W = 4;

  logic clk;
  logic rst_n;
  logic state_dbg;

  piso_serializer_if #(.WIDTH(W)) bus ();

  piso_serializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    int  guard;
    logic ok;
    guard = 0;
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    forever begin
      ok = bus.load_ready;
      tick();
      if (ok) break;
      guard++;
      if (guard > 50) begin
        fail_now("send_handshake");
        break;
      end
    end
    bus.load_valid = 1'b0;
    bus.load_data  = W'($urandom);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || bus.busy) && guard < 200) begin
      tick();
      guard++;
    end
    tick();
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_busy", bus.busy, 1'b0);
  endtask

  // scoreboard: words that completed a handshake, in order
  logic [W-1:0] exp_q[$];
  logic [W-1:0] asm_word;
  logic [W-1:0] sipo;
  logic [W-1:0] sipo_exp;
  logic         sipo_pend;
  int           bitpos;

  initial begin
    asm_word  = '0;
    sipo      = '0;
    sipo_exp  = '0;
    sipo_pend = 1'b0;
    bitpos    = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      bitpos    = 0;
      sipo_pend = 1'b0;
    end else begin
      if (sipo_pend) begin
        check("sipo_loopback", sipo, sipo_exp);
        sipo_pend = 1'b0;
      end
      if (!bus.ser_valid) begin
        check("idle_ser_out_zero", bus.ser_out, 1'b0);
      end else begin
        asm_word[bitpos] = bus.ser_out;
        sipo = {bus.ser_out, sipo[W-1:1]};
        check("ser_last_position", bus.ser_last, (bitpos == W - 1));
        if (bitpos == W - 1) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_word: got 0x%0h with nothing queued", asm_word);
          end else begin
            sipo_exp = exp_q.pop_front();
            check("word_stream", asm_word, sipo_exp);
            sipo_pend = 1'b1;
          end
          bitpos = 0;
        end else begin
          bitpos++;
        end
      end
      if (bus.load_valid && bus.load_ready) exp_q.push_back(bus.load_data);
    end
  end

  typedef struct {
    logic [W-1:0] data;
    logic [0:W-1] seq;   // expected ser_out, first cycle at index 0
  } vec_t;

  vec_t vecs[6];
  logic [0:7] b2b_seq;
  logic [0:3] seq3;

  initial begin
    vecs[0] = '{data: 4'b1011, seq: 4'b1101};
    vecs[1] = '{data: 4'b0000, seq: 4'b0000};
    vecs[2] = '{data: 4'b1111, seq: 4'b1111};
    vecs[3] = '{data: 4'b0001, seq: 4'b1000};
    vecs[4] = '{data: 4'b1000, seq: 4'b0001};
    vecs[5] = '{data: 4'b0110, seq: 4'b0110};
    b2b_seq = 8'b0101_1010;
    seq3    = 4'b1100;

    bus.load_valid = 1'b0;
    bus.load_data  = '0;

    // reset held with a word offered
    rst_n = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data  = 4'hF;
    repeat (3) tick();
    check("rst_load_ready", bus.load_ready, 1'b1);
    check("rst_ser_valid", bus.ser_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_ser_out", bus.ser_out, 1'b0);
    check("rst_ser_last", bus.ser_last, 1'b0);
    bus.load_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) tick();
    check("post_rst_busy", bus.busy, 1'b0);
    check("post_rst_ser_valid", bus.ser_valid, 1'b0);
    check("post_rst_load_ready", bus.load_ready, 1'b1);

    // single words from the table
    for (int v = 0; v < 6; v++) begin
      send(vecs[v].data);
      check("single_hold_busy", bus.busy, 1'b1);
      check("single_hold_valid", bus.ser_valid, 1'b0);
      for (int c = 0; c < W; c++) begin
        tick();
        check("single_ser_valid", bus.ser_valid, 1'b1);
        check("single_ser_out", bus.ser_out, vecs[v].seq[c]);
        check("single_ser_last", bus.ser_last, (c == W - 1));
      end
      tick();
      check("single_end_valid", bus.ser_valid, 1'b0);
      check("single_end_busy", bus.busy, 1'b0);
      check("single_end_ready", bus.load_ready, 1'b1);
    end

    // back-to-back: 0xA then 0x5 with load_valid held high
    bus.load_valid = 1'b1;
    bus.load_data  = 4'hA;
    tick();
    bus.load_data  = 4'h5;
    for (int c = 1; c <= 8; c++) begin
      if (c == 2) check("b2b_ready_before_edge2", bus.load_ready, 1'b1);
      tick();
      if (c == 2) bus.load_valid = 1'b0;
      check("b2b_ser_valid", bus.ser_valid, 1'b1);
      check("b2b_ser_out", bus.ser_out, b2b_seq[c-1]);
      check("b2b_ser_last", bus.ser_last, (c == 4 || c == 8));
    end
    tick();
    check("b2b_end_valid", bus.ser_valid, 1'b0);
    check("b2b_end_busy", bus.busy, 1'b0);

    // backpressure: shifter busy and buffer full
    send(4'hA);
    send(4'hC);
    bus.load_valid = 1'b1;
    bus.load_data  = 4'h6;
    check("bp_ready_low", bus.load_ready, 1'b0);
    check("bp_busy", bus.busy, 1'b1);
    send(4'h6);
    drain();

    // reset in the middle of a word
    send(4'hF);
    tick();
    tick();
    check("midrst_valid_before", bus.ser_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ser_valid", bus.ser_valid, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_ready", bus.load_ready, 1'b1);
    check("midrst_ser_out", bus.ser_out, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(4'h3);
    for (int c = 0; c < W; c++) begin
      tick();
      check("midrst_new_valid", bus.ser_valid, 1'b1);
      check("midrst_new_out", bus.ser_out, seq3[c]);
    end
    drain();

    // randomized words with random gaps
    for (int i = 0; i < 150; i++) begin
      int gap;
      gap = $urandom_range(0, W + 1);
      repeat (gap) tick();
      send(W'($urandom));
    end
    drain();

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
